mem_writeback: RTL and testbench
================================

# mem_writeback

Back end of the RV32I five-stage pipeline: holds the EX/MEM and MEM/WB pipeline registers and drives the data-memory port. It performs load-byte extraction and sign/zero extension, and selects the write-back value. It produces `w_enW`, `RDW` and `result`, which feed the register-file write port in the decode stage. This closes the loop opened by the decode stage's register-file reads.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `Flush`  in  1  turns the instruction entering MEM into a bubble (trap or watchdog redirect).
- `ALUResultE`  in  32  ALU result, or the effective address for loads and stores.
- `StoreDataE`  in  32  forwarded rs2 value for stores.
- `PCE_4`  in  32  PC+4 of the execute-stage instruction.
- `Instruction_Execute`  in  32  raw instruction in execute.
- `RDE`  in  5  destination register.
- `w_enE`, `wd_enE`, `rd_enE`  in  1 each  register write, memory write, and memory read enables.
- `op_selE`  in  3  func3 (load/store width and signedness).
- `WBSelE`  in  2  write-back source: 00 ALU, 01 load data, 10 PC+4, 11 ALU.
- `dmem_addr`  out  32  word-aligned address `{ALUResultM[31:2],2'b00}`.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_be`  out  4  byte enables.
- `dmem_we`, `dmem_re`  out  1 each  memory write and read strobes.
- `dmem_rdata`  in  32  synchronous-read data, valid the cycle after `dmem_re`.
- `ALUResultM`, `RDM`, `w_enM`  out  32/5/1  MEM-stage values for forwarding.
- `w_enW`  out  1  register-file write enable (never 1 when `RDW`=0).
- `RDW`  out  5  write-back destination.
- `result`  out  32  write-back data.
- `Instruction_W`  out  32  instruction retiring in WB.

## Operation
- **EX/MEM register** captures all E inputs every cycle.
  - Under `Flush`, it captures a bubble instead: all enables 0, RD 0, data 0, instruction 0x00000013.
- **MEM stage, store data (`wd_enM`):**
  - SB: byte replicated to all four lanes; `dmem_be` = 1<<addr[1:0].
  - SH: halfword replicated to both halves; `dmem_be` = addr[1] ? 1100 : 0011.
  - SW: `dmem_be` = 1111.
  - addr[0] is ignored for SH; addr[1:0] are ignored for SW. No misalignment trap.
- **MEM stage, strobes:** `dmem_we`=`wd_enM`, `dmem_re`=`rd_enM`. `dmem_be`=0000 when neither is set.
- **MEM/WB register** captures RD, w_en, WBSel, op_sel, addr[1:0], ALU result, PC+4 and instruction. It is not affected by `Flush`.
- **WB load extraction** is combinational on `dmem_rdata`:
  - LB/LBU: byte at addr[1:0], sign- or zero-extended.
  - LH/LHU: half selected by addr[1], sign- or zero-extended.
  - LW: full word.
  - Undefined func3 (011, 110, 111) returns the full word.
- **WB result mux** per WBSel.
- **`w_enW`** = `w_enWreg` && (`RDW`≠0).
- **Reset:** every register and every output is 0, including `dmem_*` strobes, `w_enW`, `RDW`, `result` and `Instruction_W`.

## Timing
- An instruction in E during cycle n is in M during n+1 and in W during n+2.
- `result` and `w_enW` are valid throughout n+2; the register file writes at the end of n+2.
- A load issues `dmem_re` in n+1. Its `dmem_rdata` arrives in n+2 and is extended combinationally with zero added latency.
- `Flush` asserted in cycle n kills only the E instruction of cycle n. Instructions already in M or W complete, so a store already in M still writes.
- `Flush` together with a store in E means no `dmem_we` in n+1.
- Reset asserted mid-operation clears all outputs immediately (asynchronously). No pending write survives reset.
- Back-to-back loads and stores are supported with one instruction per cycle and no stalls.

## Structure
- Shared package `rv32_pkg`:
  - WBSel encoding constants (WB_ALU, WB_MEM, WB_PC4).
  - Load/store func3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - NOP constant 32'h00000013.
- Sub-module `load_align`: combinational extraction from rdata, addr[1:0] and func3.

## Test plan
- **Reset:** reset asserted mid-stream → all outputs 0 asynchronously; after release, first `w_enW` is exactly 2 cycles after the first valid E instruction.
- **ALU write-back:** ADD with RDE=5, ALUResultE=0x1234, WBSel=00 → cycle n+2: `w_enW`=1, `RDW`=5, `result`=0x1234. Repeat with RDE=0 → `w_enW`=0.
- **Store byte:** SB with addr 0x103, data 0xAB → n+1: `dmem_addr`=0x100, `dmem_be`=1000, `dmem_wdata`=0xABABABAB, `dmem_we`=1.
- **Loads from one word:** memory word 0x80F1_7F02 at 0x200.
  - LB @0x203 → `result`=0xFFFFFF80.
  - LBU @0x203 → 0x00000080.
  - LH @0x202 → 0xFFFF80F1.
  - LHU @0x200 → 0x00007F02.
  - LW → 0x80F17F02.
- **JAL link:** WBSel=10 with PCE_4=0x44 → `result`=0x44 at n+2.
- **Flush:** `Flush` with an SW in E → no `dmem_we` in n+1, `Instruction_W`=0x00000013 in n+2. The older instruction already in M still writes back.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I back-end definitions: write-back select codes, load/store
// func3 codes, the canonical NOP and the pipeline-register layouts.
package rv32_pkg;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        w_en;
        logic        wd_en;
        logic        rd_en;
        logic [2:0]  op;
        logic [1:0]  wbsel;
    } exmem_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        w_en;
        logic [1:0]  wbsel;
        logic [2:0]  op;
        logic [1:0]  off;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] instr;
    } memwb_t;

endpackage

// File: rtl/mem_writeback_if.sv
// Data-memory port: address/strobes/store data out, synchronous read data in.
interface mem_writeback_if;

    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_we;
    logic        dmem_re;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_addr, dmem_wdata, dmem_be, dmem_we, dmem_re,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_addr, dmem_wdata, dmem_be, dmem_we, dmem_re,
        output dmem_rdata
    );

endinterface

// File: rtl/mem_writeback_load_align.sv
// Load alignment: picks the addressed byte/half out of the read word and
// sign- or zero-extends it; undefined func3 codes return the whole word.
module load_align
    import rv32_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  f3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane selection and extension
    always_comb begin
        case (off_i)
            2'd0:    byte_v = rdata_i[7:0];
            2'd1:    byte_v = rdata_i[15:8];
            2'd2:    byte_v = rdata_i[23:16];
            default: byte_v = rdata_i[31:24];
        endcase
        half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (f3_i)
            F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
            F3_BU:   data_o = {24'b0, byte_v};
            F3_H:    data_o = {{16{half_v[15]}}, half_v};
            F3_HU:   data_o = {16'b0, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_writeback.sv
// RV32I back end: EX/MEM and MEM/WB pipeline registers, data-memory port
// drive and write-back value selection for the register file.
module mem_writeback
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Flush,
    input  logic [XLEN-1:0] ALUResultE,
    input  logic [XLEN-1:0] StoreDataE,
    input  logic [XLEN-1:0] PCE_4,
    input  logic [XLEN-1:0] Instruction_Execute,
    input  logic [4:0]      RDE,
    input  logic            w_enE,
    input  logic            wd_enE,
    input  logic            rd_enE,
    input  logic [2:0]      op_selE,
    input  logic [1:0]      WBSelE,
    mem_writeback_if.master dmem,
    output logic [XLEN-1:0] ALUResultM,
    output logic [4:0]      RDM,
    output logic            w_enM,
    output logic            w_enW,
    output logic [4:0]      RDW,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] Instruction_W
);

    exmem_t      exmem_d, exmem_q;
    memwb_t      memwb_d, memwb_q;
    logic [31:0] load_data;
    logic [1:0]  off_m;

    // EX/MEM capture; a flushed slot becomes a NOP bubble with all enables low
    always_comb begin
        exmem_d = '0;
        if (Flush) begin
            exmem_d.instr = NOP;
        end else begin
            exmem_d.alu   = ALUResultE;
            exmem_d.sdata = StoreDataE;
            exmem_d.pc4   = PCE_4;
            exmem_d.instr = Instruction_Execute;
            exmem_d.rd    = RDE;
            exmem_d.w_en  = w_enE;
            exmem_d.wd_en = wd_enE;
            exmem_d.rd_en = rd_enE;
            exmem_d.op    = op_selE;
            exmem_d.wbsel = WBSelE;
        end
    end

    // EX/MEM register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) exmem_q <= '0;
        else      exmem_q <= exmem_d;
    end

    assign off_m = exmem_q.alu[1:0];

    // Memory port: lane-replicated store data and width-based byte enables
    always_comb begin
        dmem.dmem_addr = {exmem_q.alu[31:2], 2'b00};
        dmem.dmem_we   = exmem_q.wd_en;
        dmem.dmem_re   = exmem_q.rd_en;
        case (exmem_q.op[1:0])
            2'b00: begin
                dmem.dmem_wdata = {4{exmem_q.sdata[7:0]}};
                dmem.dmem_be    = 4'b0001 << off_m;
            end
            2'b01: begin
                dmem.dmem_wdata = {2{exmem_q.sdata[15:0]}};
                dmem.dmem_be    = off_m[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                dmem.dmem_wdata = exmem_q.sdata;
                dmem.dmem_be    = 4'b1111;
            end
        endcase
        if (!(exmem_q.wd_en || exmem_q.rd_en)) dmem.dmem_be = '0;
    end

    assign ALUResultM = exmem_q.alu;
    assign RDM        = exmem_q.rd;
    assign w_enM      = exmem_q.w_en;

    // MEM/WB capture; in-flight M instructions always retire
    always_comb begin
        memwb_d       = '0;
        memwb_d.rd    = exmem_q.rd;
        memwb_d.w_en  = exmem_q.w_en;
        memwb_d.wbsel = exmem_q.wbsel;
        memwb_d.op    = exmem_q.op;
        memwb_d.off   = off_m;
        memwb_d.alu   = exmem_q.alu;
        memwb_d.pc4   = exmem_q.pc4;
        memwb_d.instr = exmem_q.instr;
    end

    // MEM/WB register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) memwb_q <= '0;
        else      memwb_q <= memwb_d;
    end

    load_align u_load_align (
        .rdata_i (dmem.dmem_rdata),
        .off_i   (memwb_q.off),
        .f3_i    (memwb_q.op),
        .data_o  (load_data)
    );

    // Write-back value select
    always_comb begin
        case (memwb_q.wbsel)
            WB_MEM:  result = load_data;
            WB_PC4:  result = memwb_q.pc4;
            default: result = memwb_q.alu;
        endcase
    end

    assign w_enW         = memwb_q.w_en && (memwb_q.rd != 5'd0);
    assign RDW           = memwb_q.rd;
    assign Instruction_W = memwb_q.instr;

endmodule

// File: tb/tb_mem_writeback.sv
module tb_mem_writeback;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        w_en;
        logic        wd_en;
        logic        rd_en;
        logic [2:0]  op;
        logic [1:0]  wbsel;
        logic        flush;
    } instr_t;

    typedef struct packed {
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
        logic [3:0]  m_be;
        logic        m_we;
        logic        m_re;
        logic [31:0] m_alu;
        logic [4:0]  m_rd;
        logic        m_wen;
        logic        be_chk;
        logic        wd_chk;
        logic        w_en;
        logic [4:0]  rdw;
        logic [31:0] result;
        logic [31:0] instr_w;
    } exp_t;

    typedef struct packed {
        instr_t      in;
        logic        e_we;
        logic        e_re;
        logic        chk_be;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic        chk_wd;
        logic [31:0] e_wdata;
        logic        e_wen;
        logic [4:0]  e_rdw;
        logic [31:0] e_result;
        logic [31:0] e_instr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Flush = 1'b0;
    logic [31:0] ALUResultE = '0, StoreDataE = '0, PCE_4 = '0, Instruction_Execute = '0;
    logic [4:0]  RDE = '0;
    logic        w_enE = 1'b0, wd_enE = 1'b0, rd_enE = 1'b0;
    logic [2:0]  op_selE = '0;
    logic [1:0]  WBSelE = '0;
    logic [31:0] ALUResultM, result, Instruction_W;
    logic [4:0]  RDM, RDW;
    logic        w_enM, w_enW;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [31:0] mem [512];
    logic [31:0] ref_mem [16];

    always #5 clk = ~clk;

    mem_writeback_if dif ();

    mem_writeback #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .Flush(Flush),
        .ALUResultE(ALUResultE), .StoreDataE(StoreDataE), .PCE_4(PCE_4),
        .Instruction_Execute(Instruction_Execute), .RDE(RDE),
        .w_enE(w_enE), .wd_enE(wd_enE), .rd_enE(rd_enE),
        .op_selE(op_selE), .WBSelE(WBSelE), .dmem(dif),
        .ALUResultM(ALUResultM), .RDM(RDM), .w_enM(w_enM),
        .w_enW(w_enW), .RDW(RDW), .result(result), .Instruction_W(Instruction_W)
    );

    // Synchronous-read data memory with byte-enabled writes
    always @(posedge clk) begin
        if (dif.dmem_we)
            for (int b = 0; b < 4; b++)
                if (dif.dmem_be[b]) mem[dif.dmem_addr[10:2]][8*b +: 8] <= dif.dmem_wdata[8*b +: 8];
        if (dif.dmem_re) dif.dmem_rdata <= mem[dif.dmem_addr[10:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input instr_t t);
        Flush = t.flush; ALUResultE = t.alu; StoreDataE = t.sdata; PCE_4 = t.pc4;
        Instruction_Execute = t.instr; RDE = t.rd; w_enE = t.w_en; wd_enE = t.wd_en;
        rd_enE = t.rd_en; op_selE = t.op; WBSelE = t.wbsel;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: architectural effect of one instruction, in program order
    function automatic exp_t model(input instr_t t);
        exp_t e;
        int unsigned a, off, w, bv, hv, wd, idx;
        logic [3:0] be;
        e = '0;
        if (t.flush) begin
            e.instr_w = 32'h0000_0013;
            e.be_chk  = 1'b1;
            return e;
        end
        a = t.alu; off = a % 4;
        e.m_addr = a - off; e.m_we = t.wd_en; e.m_re = t.rd_en;
        e.m_alu = t.alu; e.m_rd = t.rd; e.m_wen = t.w_en;
        if (t.wd_en) begin
            if (t.op % 4 == 0) begin
                be = 4'(1 << off); wd = (t.sdata % 256) * 32'h0101_0101;
            end else if (t.op % 4 == 1) begin
                be = (off >= 2) ? 4'd12 : 4'd3; wd = (t.sdata % 65536) * 32'h0001_0001;
            end else begin
                be = 4'd15; wd = t.sdata;
            end
            e.m_be = be; e.m_wdata = wd; e.be_chk = 1'b1; e.wd_chk = 1'b1;
            idx = (a - 32'h400) / 4;
            w = ref_mem[idx];
            for (int unsigned k = 0; k < 4; k++)
                if (be[k]) w = (w & ~(32'hFF << (8*k))) | (((wd >> (8*k)) & 32'hFF) << (8*k));
            ref_mem[idx] = w;
        end else if (!t.rd_en) begin
            e.m_be = 4'd0; e.be_chk = 1'b1;
        end
        e.rdw = t.rd; e.w_en = t.w_en && (t.rd != 0); e.instr_w = t.instr;
        if (t.wbsel == 2'd1) begin
            w  = ref_mem[(a - 32'h400) / 4];
            bv = (w >> (8*off)) & 32'hFF;
            hv = (w >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
            case (t.op)
                3'd0:    e.result = (bv >= 128) ? (bv | 32'hFFFF_FF00) : bv;
                3'd4:    e.result = bv;
                3'd1:    e.result = (hv >= 32768) ? (hv | 32'hFFFF_0000) : hv;
                3'd5:    e.result = hv;
                default: e.result = w;
            endcase
        end else if (t.wbsel == 2'd2) begin
            e.result = t.pc4;
        end else begin
            e.result = t.alu;
        end
        return e;
    endfunction

    task automatic check_m(input string tag, input exp_t e);
        check({tag, ".addr"}, dif.dmem_addr, e.m_addr);
        check({tag, ".we"}, 32'(dif.dmem_we), 32'(e.m_we));
        check({tag, ".re"}, 32'(dif.dmem_re), 32'(e.m_re));
        check({tag, ".aluM"}, ALUResultM, e.m_alu);
        check({tag, ".rdM"}, 32'(RDM), 32'(e.m_rd));
        check({tag, ".wenM"}, 32'(w_enM), 32'(e.m_wen));
        if (e.be_chk) check({tag, ".be"}, 32'(dif.dmem_be), 32'(e.m_be));
        if (e.wd_chk) check({tag, ".wdata"}, dif.dmem_wdata, e.m_wdata);
    endtask

    task automatic check_w(input string tag, input exp_t e);
        check({tag, ".wenW"}, 32'(w_enW), 32'(e.w_en));
        check({tag, ".rdW"}, 32'(RDW), 32'(e.rdw));
        check({tag, ".result"}, result, e.result);
        check({tag, ".instrW"}, Instruction_W, e.instr_w);
    endtask

    function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] sd,
                                  input logic [31:0] pc4, input logic [31:0] ins,
                                  input logic [4:0] rd, input logic wen, input logic wden,
                                  input logic rden, input logic [2:0] op,
                                  input logic [1:0] wbs, input logic fl);
        instr_t t;
        t.alu = alu; t.sdata = sd; t.pc4 = pc4; t.instr = ins; t.rd = rd; t.w_en = wen;
        t.wd_en = wden; t.rd_en = rden; t.op = op; t.wbsel = wbs; t.flush = fl;
        return t;
    endfunction

    function automatic instr_t rand_instr(input bit allow_flush);
        instr_t t;
        int unsigned kind;
        t = mk($urandom, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
               1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
        kind = $urandom_range(0, 3);
        case (kind)
            0: t.wbsel = $urandom_range(0, 1) ? 2'd3 : 2'd0;
            1: begin
                t.alu = 32'h400 + $urandom_range(0, 63);
                t.rd_en = 1'b1; t.wbsel = 2'd1; t.op = 3'($urandom_range(0, 7));
            end
            2: begin
                t.alu = 32'h400 + $urandom_range(0, 63);
                t.wd_en = 1'b1; t.w_en = 1'b0; t.op = 3'($urandom_range(0, 2));
                t.wbsel = 2'($urandom_range(0, 3));
                if (t.wbsel == 2'd1) t.wbsel = 2'd0;
            end
            default: t.wbsel = 2'd2;
        endcase
        if (allow_flush && $urandom_range(0, 7) == 0) t.flush = 1'b1;
        return t;
    endfunction

    instr_t idle_i;
    vec_t   vecs [19];
    instr_t hist [$];
    exp_t   ehist [$];

    initial begin
        idle_i = '0;

        vecs[0]  = '{mk(32'h1234, 0, 0, 32'h0000_0333, 5'd5, 1, 0, 0, 3'd0, 2'd0, 0), 0, 0, 1, 4'h0, 32'h1234, 0, 0, 1, 5'd5, 32'h1234, 32'h0000_0333};
        vecs[1]  = '{mk(32'h1234, 0, 0, 32'h0000_0033, 5'd0, 1, 0, 0, 3'd0, 2'd0, 0), 0, 0, 1, 4'h0, 32'h1234, 0, 0, 0, 5'd0, 32'h1234, 32'h0000_0033};
        vecs[2]  = '{mk(32'h200, 32'h80F1_7F02, 0, 32'h0020_2023, 5'd0, 0, 1, 0, 3'd2, 2'd0, 0), 1, 0, 1, 4'hF, 32'h200, 1, 32'h80F1_7F02, 0, 5'd0, 32'h200, 32'h0020_2023};
        vecs[3]  = '{mk(32'h103, 32'h1234_56AB, 0, 32'h0000_01A3, 5'd0, 0, 1, 0, 3'd0, 2'd0, 0), 1, 0, 1, 4'h8, 32'h100, 1, 32'hABAB_ABAB, 0, 5'd0, 32'h103, 32'h0000_01A3};
        vecs[4]  = '{mk(32'h102, 32'h1234_CAFE, 0, 32'h0000_11A3, 5'd0, 0, 1, 0, 3'd1, 2'd0, 0), 1, 0, 1, 4'hC, 32'h100, 1, 32'hCAFE_CAFE, 0, 5'd0, 32'h102, 32'h0000_11A3};
        vecs[5]  = '{mk(32'h101, 32'h0000_1111, 0, 32'h0000_21A3, 5'd0, 0, 1, 0, 3'd1, 2'd0, 0), 1, 0, 1, 4'h3, 32'h100, 1, 32'h1111_1111, 0, 5'd0, 32'h101, 32'h0000_21A3};
        vecs[6]  = '{mk(32'h203, 0, 0, 32'h0000_0503, 5'd10, 1, 0, 1, 3'd0, 2'd1, 0), 0, 1, 0, 4'h0, 32'h200, 0, 0, 1, 5'd10, 32'hFFFF_FF80, 32'h0000_0503};
        vecs[7]  = '{mk(32'h203, 0, 0, 32'h0000_4503, 5'd11, 1, 0, 1, 3'd4, 2'd1, 0), 0, 1, 0, 4'h0, 32'h200, 0, 0, 1, 5'd11, 32'h0000_0080, 32'h0000_4503};
        vecs[8]  = '{mk(32'h202, 0, 0, 32'h0000_1503, 5'd12, 1, 0, 1, 3'd1, 2'd1, 0), 0, 1, 0, 4'h0, 32'h200, 0, 0, 1, 5'd12, 32'hFFFF_80F1, 32'h0000_1503};
        vecs[9]  = '{mk(32'h200, 0, 0, 32'h0000_5503, 5'd13, 1, 0, 1, 3'd5, 2'd1, 0), 0, 1, 0, 4'h0, 32'h200, 0, 0, 1, 5'd13, 32'h0000_7F02, 32'h0000_5503};
        vecs[10] = '{mk(32'h200, 0, 0, 32'h0000_2503, 5'd14, 1, 0, 1, 3'd2, 2'd1, 0), 0, 1, 0, 4'h0, 32'h200, 0, 0, 1, 5'd14, 32'h80F1_7F02, 32'h0000_2503};
        vecs[11] = '{mk(32'h201, 0, 0, 32'h0000_3503, 5'd15, 1, 0, 1, 3'd3, 2'd1, 0), 0, 1, 0, 4'h0, 32'h200, 0, 0, 1, 5'd15, 32'h80F1_7F02, 32'h0000_3503};
        vecs[12] = '{mk(32'h201, 0, 0, 32'h0000_0583, 5'd16, 1, 0, 1, 3'd0, 2'd1, 0), 0, 1, 0, 4'h0, 32'h200, 0, 0, 1, 5'd16, 32'h0000_007F, 32'h0000_0583};
        vecs[13] = '{mk(32'h203, 0, 0, 32'h0000_1583, 5'd17, 1, 0, 1, 3'd1, 2'd1, 0), 0, 1, 0, 4'h0, 32'h200, 0, 0, 1, 5'd17, 32'hFFFF_80F1, 32'h0000_1583};
        vecs[14] = '{mk(32'h999, 0, 32'h44, 32'h0000_00EF, 5'd1, 1, 0, 0, 3'd0, 2'd2, 0), 0, 0, 1, 4'h0, 32'h998, 0, 0, 1, 5'd1, 32'h44, 32'h0000_00EF};
        vecs[15] = '{mk(32'h200, 32'h0, 0, 32'h0000_2023, 5'd3, 1, 1, 0, 3'd2, 2'd0, 1), 0, 0, 1, 4'h0, 32'h0, 1, 32'h0, 0, 5'd0, 32'h0, 32'h0000_0013};
        vecs[16] = '{mk(32'h200, 0, 0, 32'h0000_2603, 5'd18, 1, 0, 1, 3'd2, 2'd1, 0), 0, 1, 0, 4'h0, 32'h200, 0, 0, 1, 5'd18, 32'h80F1_7F02, 32'h0000_2603};
        vecs[17] = '{mk(32'hDEAD_BEEF, 0, 0, 32'h0000_0FB3, 5'd31, 1, 0, 0, 3'd0, 2'd3, 0), 0, 0, 1, 4'h0, 32'hDEAD_BEEC, 0, 0, 1, 5'd31, 32'hDEAD_BEEF, 32'h0000_0FB3};
        vecs[18] = '{mk(32'h100, 0, 0, 32'h0000_2683, 5'd19, 1, 0, 1, 3'd2, 2'd1, 0), 0, 1, 0, 4'h0, 32'h100, 0, 0, 1, 5'd19, 32'hCAFE_1111, 32'h0000_2683};

        // Reset state
        drive(idle_i);
        step(); step();
        check("rst.wenW", 32'(w_enW), 0);
        check("rst.result", result, 0);
        check("rst.instrW", Instruction_W, 0);
        check("rst.we", 32'(dif.dmem_we), 0);
        rst = 1'b1;

        // Directed table: one instruction followed by a bubble each
        foreach (vecs[i]) begin
            drive(vecs[i].in);
            step();
            check($sformatf("v%0d.we", i), 32'(dif.dmem_we), 32'(vecs[i].e_we));
            check($sformatf("v%0d.re", i), 32'(dif.dmem_re), 32'(vecs[i].e_re));
            check($sformatf("v%0d.addr", i), dif.dmem_addr, vecs[i].e_addr);
            if (vecs[i].chk_be) check($sformatf("v%0d.be", i), 32'(dif.dmem_be), 32'(vecs[i].e_be));
            if (vecs[i].chk_wd) check($sformatf("v%0d.wdata", i), dif.dmem_wdata, vecs[i].e_wdata);
            drive(idle_i);
            step();
            check($sformatf("v%0d.wenW", i), 32'(w_enW), 32'(vecs[i].e_wen));
            check($sformatf("v%0d.rdW", i), 32'(RDW), 32'(vecs[i].e_rdw));
            check($sformatf("v%0d.result", i), result, vecs[i].e_result);
            check($sformatf("v%0d.instrW", i), Instruction_W, vecs[i].e_instr);
        end

        // Flush with an older ALU op in M and a store in E: the older op retires
        drive(mk(32'hBEEF, 0, 0, 32'h0000_0393, 5'd7, 1, 0, 0, 3'd0, 2'd0, 0));
        step();
        drive(mk(32'h300, 32'h55, 0, 32'h0000_2023, 5'd0, 0, 1, 0, 3'd2, 2'd0, 1));
        check("fl.older_rdM", 32'(RDM), 7);
        step();
        drive(idle_i);
        check("fl.no_we", 32'(dif.dmem_we), 0);
        check("fl.older_wenW", 32'(w_enW), 1);
        check("fl.older_result", result, 32'hBEEF);
        step();
        check("fl.bubble_instrW", Instruction_W, 32'h0000_0013);
        check("fl.bubble_wenW", 32'(w_enW), 0);

        // A store already in M still writes when the younger slot is flushed
        drive(mk(32'h304, 32'h1357_9BDF, 0, 32'h0000_2223, 5'd0, 0, 1, 0, 3'd2, 2'd0, 0));
        step();
        drive(mk(32'h0, 0, 0, 32'h0000_0013, 5'd0, 0, 0, 0, 3'd0, 2'd0, 1));
        check("fl.m_store_we", 32'(dif.dmem_we), 1);
        step();
        drive(mk(32'h304, 0, 0, 32'h0000_2703, 5'd20, 1, 0, 1, 3'd2, 2'd1, 0));
        step();
        drive(idle_i);
        step();
        check("fl.m_store_landed", result, 32'h1357_9BDF);

        // Reset mid-stream with a store pending in M
        drive(mk(32'h3F0, 32'hFFFF_FFFF, 0, 32'h0000_2023, 5'd0, 0, 1, 0, 3'd2, 2'd0, 0));
        step();
        drive(mk(32'h1, 0, 0, 32'h0000_0093, 5'd1, 1, 0, 0, 3'd0, 2'd0, 0));
        step();
        #2 rst = 1'b0;
        #1;
        check("mrst.we", 32'(dif.dmem_we), 0);
        check("mrst.addr", dif.dmem_addr, 0);
        check("mrst.wenW", 32'(w_enW), 0);
        check("mrst.rdW", 32'(RDW), 0);
        check("mrst.result", result, 0);
        check("mrst.instrW", Instruction_W, 0);
        check("mrst.wenM", 32'(w_enM), 0);
        drive(idle_i);
        step();
        rst = 1'b1;
        drive(mk(32'h77, 0, 0, 32'h0000_0493, 5'd9, 1, 0, 0, 3'd0, 2'd0, 0));
        step();
        drive(idle_i);
        check("mrst.n1_wenW", 32'(w_enW), 0);
        step();
        check("mrst.n2_wenW", 32'(w_enW), 1);
        check("mrst.n2_result", result, 32'h77);

        // Random stream: preload the region with full-word stores, then mix
        for (int unsigned k = 0; k < 16; k++) begin
            hist.push_back(mk(32'h400 + 4*k, $urandom, 0, $urandom, 5'd0, 0, 1, 0, 3'd2, 2'd0, 0));
        end
        for (int unsigned k = 0; k < 400; k++) hist.push_back(rand_instr(1'b1));
        hist.push_back(idle_i);
        hist.push_back(idle_i);
        foreach (hist[i]) ehist.push_back(model(hist[i]));
        foreach (hist[i]) begin
            drive(hist[i]);
            step();
            check_m($sformatf("r%0d.M", i), ehist[i]);
            if (i > 0) check_w($sformatf("r%0d.W", i - 1), ehist[i - 1]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
